// File: rtl/audio_gen_pkg.sv
// Shared types for the test-signal generator audio path.
// Holds the crossfade source-selector state encoding.
package audio_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FADE = 1'b1
   } xfade_state_t;

endpackage : audio_gen_pkg

// File: rtl/xfade_blend.sv
// Linear crossfade between two signed samples.
// Computes (a*(2^RAMP_SHIFT - cnt) + b*cnt) >>> RAMP_SHIFT, rounding toward -inf.
module xfade_blend #(
   parameter int WIDTH      = 16,
   parameter int RAMP_SHIFT = 6
) (
   input  logic signed [WIDTH-1:0]      a,
   input  logic signed [WIDTH-1:0]      b,
   input  logic        [RAMP_SHIFT-1:0] cnt,
   output logic signed [WIDTH-1:0]      y
);

   localparam int P = WIDTH + RAMP_SHIFT + 1;

   logic        [RAMP_SHIFT:0] wa_s;
   logic signed [P-1:0]        a_ext_s;
   logic signed [P-1:0]        b_ext_s;
   logic signed [P-1:0]        wa_ext_s;
   logic signed [P-1:0]        wb_ext_s;
   logic signed [P-1:0]        sum_s;

   // Weights are non-negative, so they are zero-extended into the signed product width.
   assign wa_s     = {1'b1, {RAMP_SHIFT{1'b0}}} - {1'b0, cnt};
   assign a_ext_s  = {{(RAMP_SHIFT + 1){a[WIDTH-1]}}, a};
   assign b_ext_s  = {{(RAMP_SHIFT + 1){b[WIDTH-1]}}, b};
   assign wa_ext_s = {{WIDTH{1'b0}}, wa_s};
   assign wb_ext_s = {{(WIDTH + 1){1'b0}}, cnt};

   // Convex combination: the shifted sum always fits back into WIDTH bits.
   assign sum_s = (a_ext_s * wa_ext_s) + (b_ext_s * wb_ext_s);
   assign y     = WIDTH'(sum_s >>> RAMP_SHIFT);

endmodule : xfade_blend

// File: rtl/xfade_source_mux.sv
// N-channel source selector for the test-signal generator; a source change is
// applied as a linear crossfade over 2^RAMP_SHIFT sample strobes.
module xfade_source_mux
   import audio_gen_pkg::*;
#(
   parameter  int N_CH       = 5,
   parameter  int WIDTH      = 16,
   parameter  int RAMP_SHIFT = 6,
   localparam int SEL_W      = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample_en,
   input  logic [SEL_W-1:0]         sel,
   input  logic [N_CH*WIDTH-1:0]    d,
   output logic signed [WIDTH-1:0]  y,
   output logic                     y_valid,
   output logic                     busy
);

   localparam logic [RAMP_SHIFT-1:0] CNT_LAST = {RAMP_SHIFT{1'b1}};
   localparam logic [SEL_W:0]        N_CH_L   = (SEL_W + 1)'(N_CH);

   xfade_state_t             state_r;
   logic [SEL_W-1:0]         cur_sel_r;
   logic [SEL_W-1:0]         nxt_sel_r;
   logic [RAMP_SHIFT-1:0]    cnt_r;
   logic signed [WIDTH-1:0]  y_r;
   logic                     y_valid_r;
   logic                     busy_r;

   logic signed [WIDTH-1:0]  a_s;
   logic signed [WIDTH-1:0]  b_s;
   logic signed [WIDTH-1:0]  blend_s;
   logic                     sel_ok_s;

   function automatic logic signed [WIDTH-1:0] pick_ch(
      input logic [N_CH*WIDTH-1:0] bus,
      input logic [SEL_W-1:0]      idx
   );
      logic signed [WIDTH-1:0] r;
      r = {WIDTH{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         if (idx == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
      end
      return r;
   endfunction

   // Live channel extraction: both fade endpoints track their inputs every sample.
   assign a_s = pick_ch(d, cur_sel_r);
   assign b_s = pick_ch(d, nxt_sel_r);

   // Out-of-range and unchanged requests never start a fade.
   assign sel_ok_s = ({1'b0, sel} < N_CH_L) && (sel != cur_sel_r);

   xfade_blend #(
      .WIDTH      (WIDTH),
      .RAMP_SHIFT (RAMP_SHIFT)
   ) u_blend (
      .a   (a_s),
      .b   (b_s),
      .cnt (cnt_r),
      .y   (blend_s)
   );

   // Selector FSM, fade counter and output registers; all advance only on sample strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cur_sel_r <= {SEL_W{1'b0}};
         nxt_sel_r <= {SEL_W{1'b0}};
         cnt_r     <= {RAMP_SHIFT{1'b0}};
         y_r       <= {WIDTH{1'b0}};
         y_valid_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         y_valid_r <= sample_en;
         if (sample_en) begin
            case (state_r)
               IDLE: begin
                  y_r <= a_s;
                  if (sel_ok_s) begin
                     nxt_sel_r <= sel;
                     cnt_r     <= {RAMP_SHIFT{1'b0}};
                     state_r   <= FADE;
                     busy_r    <= 1'b1;
                  end
               end
               FADE: begin
                  y_r <= blend_s;
                  if (cnt_r == CNT_LAST) begin
                     cur_sel_r <= nxt_sel_r;
                     cnt_r     <= {RAMP_SHIFT{1'b0}};
                     state_r   <= IDLE;
                     busy_r    <= 1'b0;
                  end else begin
                     cnt_r <= cnt_r + {{(RAMP_SHIFT - 1){1'b0}}, 1'b1};
                  end
               end
               default: begin
                  state_r <= IDLE;
                  cnt_r   <= {RAMP_SHIFT{1'b0}};
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign y       = y_r;
   assign y_valid = y_valid_r;
   assign busy    = busy_r;

endmodule : xfade_source_mux
